// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the pipelined ALU control: ALU_Op classes, ALU operation
// codes and the multi-cycle classifier.
package alu_ctrl_pkg;

   localparam logic [2:0] AOP_R    = 3'b000;
   localparam logic [2:0] AOP_I    = 3'b001;
   localparam logic [2:0] AOP_LW   = 3'b010;
   localparam logic [2:0] AOP_JALR = 3'b011;
   localparam logic [2:0] AOP_SW   = 3'b100;
   localparam logic [2:0] AOP_B    = 3'b101;
   localparam logic [2:0] AOP_JAL  = 3'b110;
   localparam logic [2:0] AOP_LUI  = 3'b111;

   localparam logic [4:0] OP_ADD  = 5'd0;
   localparam logic [4:0] OP_SUB  = 5'd1;
   localparam logic [4:0] OP_XOR  = 5'd2;
   localparam logic [4:0] OP_OR   = 5'd3;
   localparam logic [4:0] OP_AND  = 5'd4;
   localparam logic [4:0] OP_SLL  = 5'd5;
   localparam logic [4:0] OP_SRL  = 5'd6;
   localparam logic [4:0] OP_SRA  = 5'd7;
   localparam logic [4:0] OP_SLT  = 5'd8;
   localparam logic [4:0] OP_SLTU = 5'd9;
   localparam logic [4:0] OP_BEQ  = 5'd10;
   localparam logic [4:0] OP_BNE  = 5'd11;
   localparam logic [4:0] OP_BLT  = 5'd12;
   localparam logic [4:0] OP_BGE  = 5'd13;
   localparam logic [4:0] OP_BLTU = 5'd14;
   localparam logic [4:0] OP_BGEU = 5'd15;
   localparam logic [4:0] OP_JAL  = 5'd16;
   localparam logic [4:0] OP_LUI  = 5'd17;
   localparam logic [4:0] OP_MUL  = 5'd18;
   localparam logic [4:0] OP_MULH = 5'd19;
   localparam logic [4:0] OP_DIV  = 5'd20;
   localparam logic [4:0] OP_REM  = 5'd21;

   function automatic logic is_multicycle(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic is_mul(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_MULH);
   endfunction

endpackage

// File: rtl/alu_control_pipe_decode.sv
// Combinational decode of ALU_Op/funct3/funct7 into an ALU operation code.
// Unsupported encodings fall back to ADD with illegal raised.
module alu_op_decode
   import alu_ctrl_pkg::*;
#(
   parameter int OP_W  = 5,
   parameter int M_EXT = 1
) (
   input  logic [2:0]      alu_op,
   input  logic [2:0]      funct3,
   input  logic            funct7_5,
   input  logic            funct7_0,
   output logic [OP_W-1:0] op,
   output logic            illegal,
   output logic            multicycle
);

   logic [4:0] code;

   // Shared R/I arithmetic table; funct3=000 handled by the caller.
   function automatic logic [4:0] arith(input logic [2:0] f3, input logic f75);
      case (f3)
         3'b001:  return OP_SLL;
         3'b010:  return OP_SLT;
         3'b011:  return OP_SLTU;
         3'b100:  return OP_XOR;
         3'b101:  return f75 ? OP_SRA : OP_SRL;
         3'b110:  return OP_OR;
         3'b111:  return OP_AND;
         default: return f75 ? OP_SUB : OP_ADD;
      endcase
   endfunction

   always_comb begin
      code    = OP_ADD;
      illegal = 1'b0;
      case (alu_op)
         AOP_R: begin
            if (funct7_0) begin
               if (M_EXT != 0) begin
                  case (funct3)
                     3'b000:  code = OP_MUL;
                     3'b001:  code = OP_MULH;
                     3'b100:  code = OP_DIV;
                     3'b110:  code = OP_REM;
                     default: illegal = 1'b1;
                  endcase
               end else begin
                  illegal = 1'b1;
               end
            end else begin
               code = arith(funct3, funct7_5);
            end
         end
         AOP_I: begin
            if (funct3 == 3'b001 && funct7_5) illegal = 1'b1;
            else if (funct3 != 3'b000)        code = arith(funct3, funct7_5);
         end
         AOP_B: begin
            case (funct3)
               3'b000:  code = OP_BEQ;
               3'b001:  code = OP_BNE;
               3'b100:  code = OP_BLT;
               3'b101:  code = OP_BGE;
               3'b110:  code = OP_BLTU;
               3'b111:  code = OP_BGEU;
               default: illegal = 1'b1;
            endcase
         end
         AOP_JAL: code = OP_JAL;
         AOP_LUI: code = OP_LUI;
         default: code = OP_ADD;
      endcase
   end

   assign op         = OP_W'(code);
   assign multicycle = is_multicycle(code);

endmodule

// File: rtl/alu_control_pipe.sv
// EX-stage register for the decoded ALU op plus the IDLE/BUSY sequencer that
// stalls ID while a MUL/DIV with latency > 1 occupies EX.
module alu_control_pipe
   import alu_ctrl_pkg::*;
#(
   parameter int OP_W    = 5,
   parameter int M_EXT   = 1,
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            id_valid_i,
   input  logic [2:0]      alu_op_i,
   input  logic [2:0]      funct3_i,
   input  logic            funct7_5_i,
   input  logic            funct7_0_i,
   input  logic            flush_i,
   output logic [OP_W-1:0] ex_op_o,
   output logic            ex_valid_o,
   output logic            ex_illegal_o,
   output logic            stall_o,
   output logic            mc_done_o
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [OP_W-1:0]   dec_op;
   logic              dec_illegal;
   logic              dec_mc;
   logic              dec_mul;
   logic              mc_start;
   logic [CNT_W-1:0]  mc_load;

   alu_op_decode #(.OP_W(OP_W), .M_EXT(M_EXT)) u_dec (
      .alu_op     (alu_op_i),
      .funct3     (funct3_i),
      .funct7_5   (funct7_5_i),
      .funct7_0   (funct7_0_i),
      .op         (dec_op),
      .illegal    (dec_illegal),
      .multicycle (dec_mc)
   );

   assign dec_mul  = is_mul(dec_op[4:0]);
   // Latency 1 ops retire like ordinary single-cycle ops.
   assign mc_start = dec_mc && (dec_mul ? (MUL_LAT > 1) : (DIV_LAT > 1));
   assign mc_load  = dec_mul ? CNT_W'(MUL_LAT - 1) : CNT_W'(DIV_LAT - 1);
   assign stall_o  = (state == BUSY);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         ex_op_o      <= OP_W'(OP_ADD);
         ex_valid_o   <= 1'b0;
         ex_illegal_o <= 1'b0;
         mc_done_o    <= 1'b0;
      end else begin
         mc_done_o <= 1'b0;
         if (flush_i) begin
            state        <= IDLE;
            cnt          <= '0;
            ex_valid_o   <= 1'b0;
            ex_illegal_o <= 1'b0;
         end else if (state == BUSY) begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
               state     <= IDLE;
               mc_done_o <= 1'b1;
            end
         end else begin
            ex_valid_o <= id_valid_i;
            if (id_valid_i) begin
               ex_op_o      <= dec_op;
               ex_illegal_o <= dec_illegal;
               if (mc_start) begin
                  state <= BUSY;
                  cnt   <= mc_load;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_control_pipe.sv
// Scoreboard bench for alu_control_pipe: M_EXT=1 main instance plus an
// M_EXT=0 instance sharing the same ID-side stimulus.
module tb_alu_control_pipe;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid_i;
   logic [2:0] alu_op_i;
   logic [2:0] funct3_i;
   logic       funct7_5_i;
   logic       funct7_0_i;
   logic       flush_i;
   logic [4:0] ex_op_o, nm_op;
   logic       ex_valid_o, ex_illegal_o, stall_o, mc_done_o;
   logic       nm_valid, nm_illegal, nm_stall, nm_done;

   typedef struct {logic [4:0] op; logic ill;} exp_t;
   exp_t sb[$];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_control_pipe #(.OP_W(5), .M_EXT(1), .MUL_LAT(3), .DIV_LAT(8)) dut (
      .clk(clk), .reset(reset), .id_valid_i(id_valid_i), .alu_op_i(alu_op_i),
      .funct3_i(funct3_i), .funct7_5_i(funct7_5_i), .funct7_0_i(funct7_0_i),
      .flush_i(flush_i), .ex_op_o(ex_op_o), .ex_valid_o(ex_valid_o),
      .ex_illegal_o(ex_illegal_o), .stall_o(stall_o), .mc_done_o(mc_done_o)
   );

   alu_control_pipe #(.OP_W(5), .M_EXT(0), .MUL_LAT(3), .DIV_LAT(8)) dut_nm (
      .clk(clk), .reset(reset), .id_valid_i(id_valid_i), .alu_op_i(alu_op_i),
      .funct3_i(funct3_i), .funct7_5_i(funct7_5_i), .funct7_0_i(funct7_0_i),
      .flush_i(flush_i), .ex_op_o(nm_op), .ex_valid_o(nm_valid),
      .ex_illegal_o(nm_illegal), .stall_o(nm_stall), .mc_done_o(nm_done)
   );

   task automatic chk(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", tag, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] aop, input logic [2:0] f3,
                        input logic f75, input logic f70);
      @(negedge clk);
      id_valid_i = v; alu_op_i = aop; funct3_i = f3; funct7_5_i = f75; funct7_0_i = f70;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 1, 0);
      end else begin
         e = sb.pop_front();
         chk({tag, "_op"}, ex_op_o, e.op);
         chk({tag, "_ill"}, ex_illegal_o, e.ill);
         chk({tag, "_vld"}, ex_valid_o, 1);
      end
   endtask

   // Drive one instruction, push its expectation, and check it one edge later.
   task automatic issue(input string tag, input logic [2:0] aop, input logic [2:0] f3,
                        input logic f75, input logic f70, input logic [4:0] eop,
                        input logic eill);
      exp_t e;
      drive(1'b1, aop, f3, f75, f70);
      e.op = eop; e.ill = eill;
      sb.push_back(e);
      step();
      pop_check(tag);
   endtask

   typedef struct {logic [2:0] aop; logic [2:0] f3; logic f75; logic f70;
                   logic [4:0] op; logic ill;} vec_t;

   initial begin
      vec_t vt[14];
      int   stall_cnt, done_cnt;

      vt[0]  = '{3'b000, 3'b000, 1'b1, 1'b0, 5'd1,  1'b0}; // R SUB
      vt[1]  = '{3'b001, 3'b000, 1'b1, 1'b0, 5'd0,  1'b0}; // I ADD despite f7_5
      vt[2]  = '{3'b000, 3'b101, 1'b1, 1'b0, 5'd7,  1'b0}; // SRA
      vt[3]  = '{3'b000, 3'b011, 1'b0, 1'b0, 5'd9,  1'b0}; // SLTU
      vt[4]  = '{3'b001, 3'b001, 1'b1, 1'b0, 5'd0,  1'b1}; // I SLL f7_5 illegal
      vt[5]  = '{3'b101, 3'b010, 1'b0, 1'b0, 5'd0,  1'b1}; // B 010 illegal
      vt[6]  = '{3'b101, 3'b111, 1'b0, 1'b0, 5'd15, 1'b0}; // BGEU
      vt[7]  = '{3'b101, 3'b000, 1'b0, 1'b0, 5'd10, 1'b0}; // BEQ
      vt[8]  = '{3'b110, 3'b101, 1'b1, 1'b1, 5'd16, 1'b0}; // JAL
      vt[9]  = '{3'b111, 3'b000, 1'b0, 1'b0, 5'd17, 1'b0}; // LUI
      vt[10] = '{3'b100, 3'b111, 1'b1, 1'b1, 5'd0,  1'b0}; // SW
      vt[11] = '{3'b000, 3'b010, 1'b0, 1'b1, 5'd0,  1'b1}; // M funct3 010 illegal
      vt[12] = '{3'b001, 3'b101, 1'b0, 1'b1, 5'd6,  1'b0}; // I SRL, f7_0 ignored
      vt[13] = '{3'b000, 3'b111, 1'b0, 1'b0, 5'd4,  1'b0}; // AND

      reset = 1'b1; flush_i = 1'b0; id_valid_i = 1'b0;
      alu_op_i = '0; funct3_i = '0; funct7_5_i = 1'b0; funct7_0_i = 1'b0;
      #2;
      chk("rst_op", ex_op_o, 0);
      chk("rst_vld", ex_valid_o, 0);
      chk("rst_ill", ex_illegal_o, 0);
      chk("rst_stall", stall_o, 0);
      chk("rst_done", mc_done_o, 0);
      @(negedge clk); reset = 1'b0;

      foreach (vt[i]) begin
         issue($sformatf("dec%0d", i), vt[i].aop, vt[i].f3, vt[i].f75, vt[i].f70,
               vt[i].op, vt[i].ill);
         chk($sformatf("dec%0d_stall", i), stall_o, 0);
      end

      // Bubble: valid drops, op holds AND from the last vector.
      drive(1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
      step();
      chk("bubble_vld", ex_valid_o, 0);
      chk("bubble_hold", ex_op_o, 4);

      // MUL on both instances: M_EXT=1 stalls, M_EXT=0 flags illegal.
      issue("mul", 3'b000, 3'b000, 1'b0, 1'b1, 5'd18, 1'b0);
      chk("mul_stall1", stall_o, 1);
      chk("mul_done1", mc_done_o, 0);
      chk("nm_op", nm_op, 0);
      chk("nm_ill", nm_illegal, 1);
      chk("nm_stall1", nm_stall, 0);
      drive(1'b1, 3'b000, 3'b100, 1'b0, 1'b0);  // XOR waits in ID
      sb.push_back('{5'd2, 1'b0});
      step();
      chk("mul_stall2", stall_o, 1);
      chk("mul_op2", ex_op_o, 18);
      chk("mul_done2", mc_done_o, 0);
      chk("nm_stall2", nm_stall, 0);
      step();
      chk("mul_stall3", stall_o, 0);
      chk("mul_done3", mc_done_o, 1);
      chk("mul_op3", ex_op_o, 18);
      step();
      pop_check("after_mul");
      chk("after_mul_done", mc_done_o, 0);

      // DIV flushed in its 4th busy cycle: no done pulse afterwards.
      issue("divf", 3'b000, 3'b100, 1'b0, 1'b1, 5'd20, 1'b0);
      drive(1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
      step(); step(); step();
      chk("divf_stall4", stall_o, 1);
      @(negedge clk); flush_i = 1'b1;
      step();
      @(negedge clk); flush_i = 1'b0;
      chk("flush_vld", ex_valid_o, 0);
      chk("flush_ill", ex_illegal_o, 0);
      chk("flush_stall", stall_o, 0);
      chk("flush_done", mc_done_o, 0);
      done_cnt = 0; stall_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         done_cnt  += int'(mc_done_o);
         stall_cnt += int'(stall_o);
      end
      chk("flush_no_done", done_cnt, 0);
      chk("flush_no_stall", stall_cnt, 0);

      // DIV interrupted by reset on its 3rd busy cycle.
      issue("divr", 3'b000, 3'b110, 1'b0, 1'b1, 5'd21, 1'b0);
      drive(1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
      step(); step();
      chk("divr_stall3", stall_o, 1);
      @(negedge clk); reset = 1'b1;
      #1;
      chk("arst_op", ex_op_o, 0);
      chk("arst_vld", ex_valid_o, 0);
      chk("arst_stall", stall_o, 0);
      chk("arst_done", mc_done_o, 0);
      @(negedge clk); reset = 1'b0;

      // Full re-run: 7 stall cycles, then exactly one done pulse.
      issue("div2", 3'b000, 3'b100, 1'b0, 1'b1, 5'd20, 1'b0);
      drive(1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
      stall_cnt = int'(stall_o);
      done_cnt  = int'(mc_done_o);
      for (int k = 0; k < 11; k++) begin
         step();
         stall_cnt += int'(stall_o);
         done_cnt  += int'(mc_done_o);
      end
      chk("div2_stall_cycles", stall_cnt, 7);
      chk("div2_done_pulses", done_cnt, 1);
      chk("sb_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
